fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake, IF/ID pipeline register.
// Latency: IF/ID loads on the edge where the instruction is available (0-wait memory gives 1 instr/cycle).
// Backpressure: stallf holds the PC and parks a returned instruction in ibuf; stalld holds IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallf,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcplus4d,
  output logic        validd
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding
    S_READY = 2'd1,  // instruction parked in ibuf, PC stalled
    S_DROP  = 2'd2   // waiting to swallow a response made stale by a redirect
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] instrd_q, instrd_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;

  logic        avail;
  logic [31:0] instr_src;
  logic [31:0] pcf_plus4;

  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pcf_q;
  assign instrd    = instrd_q;
  assign pcd       = pcd_q;
  assign pcplus4d  = pcplus4d_q;
  assign validd    = validd_q;

  // Next-state for the FSM, PC, instruction buffer and IF/ID register.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    ibuf_d     = ibuf_q;
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;

    pcf_plus4 = pcf_q + 32'd4;
    avail     = ((state_q == S_FETCH) && imem_rvalid) || (state_q == S_READY);
    instr_src = (state_q == S_READY) ? ibuf_q : imem_rdata;

    case (state_q)
      S_FETCH: begin
        if (pcsrc && !imem_rvalid) begin
          state_d = S_DROP;
        end else if (pcsrc) begin
          state_d = S_FETCH;  // response belongs to the wrong path; drop it
        end else if (imem_rvalid && stallf) begin
          state_d = S_READY;
          ibuf_d  = imem_rdata;
        end
      end
      S_READY: begin
        if (pcsrc || !stallf) state_d = S_FETCH;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect beats stall beats sequential advance.
    if (pcsrc) begin
      pcf_d = pctarget;
    end else if (!stallf && avail) begin
      pcf_d = pcf_plus4;
    end

    // Flush beats stall; anything not loaded becomes a bubble.
    if (flushd) begin
      instrd_d   = NOP_INSTR;
      pcd_d      = 32'd0;
      pcplus4d_d = 32'd0;
      validd_d   = 1'b0;
    end else if (!stalld) begin
      if (avail && !pcsrc) begin
        instrd_d   = instr_src;
        pcd_d      = pcf_q;
        pcplus4d_d = pcf_plus4;
        validd_d   = 1'b1;
      end else begin
        instrd_d   = NOP_INSTR;
        pcd_d      = 32'd0;
        pcplus4d_d = 32'd0;
        validd_d   = 1'b0;
      end
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pcf_q      <= RESET_PC;
      ibuf_q     <= 32'd0;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= 32'd0;
      pcplus4d_q <= 32'd0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      ibuf_q     <= ibuf_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a variable-latency instruction memory.
// A transaction-level model predicts IF/ID and the next request; a monitor checks after each edge.
// Stimulus phases sweep 0-wait streaming, long latency, stalls, redirects, flushes and resets.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallf = 1'b0, stalld = 1'b0, flushd = 1'b0, pcsrc = 1'b0;
  logic [31:0] pctarget = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instrd, pcd, pcplus4d;
  logic        validd;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stallf(stallf), .stalld(stalld), .flushd(flushd),
    .pcsrc(pcsrc), .pctarget(pctarget),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d), .validd(validd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        vld;
    logic        fetching;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("instrd", instrd, e.instr);
        chk("pcd", pcd, e.pc);
        chk("pcplus4d", pcplus4d, e.pc4);
        chk("validd", {31'd0, validd}, {31'd0, e.vld});
        chk("imem_req", {31'd0, imem_req}, {31'd0, e.fetching && !rst});
        chk("imem_addr", imem_addr, e.addr);
      end
    end
  end

  // Reference model: next fetch address, an optional parked instruction,
  // and whether a response still due belongs to an abandoned path.
  logic [31:0] m_pc, m_held, m_instr, m_pcd, m_pc4;
  logic        m_held_v, m_stale, m_vld;

  // Memory model state.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;

  int ph_cyc  [4] = '{40, 40, 150, 160};
  int ph_stall[4] = '{0, 0, 25, 40};
  int ph_redir[4] = '{0, 0, 10, 20};
  int ph_flush[4] = '{0, 0, 10, 20};
  int ph_lat  [4] = '{0, 3, 3, 2};
  int ph_rst  [4] = '{0, 0, 0, 3};

  initial begin
    exp_t        e;
    logic        fetching, got;
    logic [31:0] word;
    m_pc = RESET_PC; m_held = 0; m_held_v = 0; m_stale = 0;
    m_instr = NOP_INSTR; m_pcd = 0; m_pc4 = 0; m_vld = 0;
    mem_pend = 0; mem_addr = 0; mem_wait = 0;

    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < ph_cyc[p]; c++) begin
        @(negedge clk);
        rst = (c < 2) || ($urandom_range(99) < ph_rst[p]);
        stallf = $urandom_range(99) < ph_stall[p];
        stalld = $urandom_range(99) < ph_stall[p];
        flushd = $urandom_range(99) < ph_flush[p];
        pcsrc  = $urandom_range(99) < ph_redir[p];
        case ($urandom_range(3))
          0:       pctarget = 32'h0000_0100;
          1:       pctarget = 32'hFFFF_FFFC;
          default: pctarget = $urandom() & 32'hFFFF_FFFC;
        endcase
        #1;
        if (rst) begin
          mem_pend = 0;
          imem_rvalid = 0;
        end else begin
          if (!mem_pend && imem_req) begin
            mem_pend = 1;
            mem_addr = imem_addr;
            mem_wait = ($urandom_range(1) == 0) ? 0 : $urandom_range(ph_lat[p]);
          end
          imem_rvalid = mem_pend && (mem_wait == 0);
        end
        imem_rdata = imem_rvalid ? mem_word(mem_addr) : $urandom();

        // Predict the effect of the coming edge.
        if (rst) begin
          m_pc = RESET_PC; m_held_v = 0; m_held = 0; m_stale = 0;
          m_instr = NOP_INSTR; m_pcd = 0; m_pc4 = 0; m_vld = 0;
        end else begin
          fetching = !m_held_v && !m_stale;
          got  = m_held_v || (fetching && imem_rvalid);
          word = m_held_v ? m_held : imem_rdata;
          if (flushd || (!stalld && !(got && !pcsrc))) begin
            m_instr = NOP_INSTR; m_pcd = 0; m_pc4 = 0; m_vld = 0;
          end else if (!stalld) begin
            m_instr = word; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_vld = 1;
          end
          if (m_held_v) begin
            if (pcsrc || !stallf) m_held_v = 0;
          end else if (m_stale) begin
            if (imem_rvalid) m_stale = 0;
          end else if (pcsrc) begin
            m_stale = !imem_rvalid;
          end else if (imem_rvalid && stallf) begin
            m_held_v = 1;
            m_held = imem_rdata;
          end
          if (pcsrc) m_pc = pctarget;
          else if (!stallf && got) m_pc = m_pc + 32'd4;
        end
        e.instr = m_instr; e.pc = m_pcd; e.pc4 = m_pc4; e.vld = m_vld;
        e.fetching = !m_held_v && !m_stale;
        e.addr = m_pc;
        sb.push_back(e);

        if (imem_rvalid) mem_pend = 0;
        else if (mem_pend) mem_wait--;
      end
    end

    @(negedge clk);
    rst = 1; stallf = 0; stalld = 0; flushd = 0; pcsrc = 0; imem_rvalid = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
